line_memory_responder: RTL

Line-granular backing memory that answers the cache's miss-handling requests: write-back of dirty lines and allocation fills. It sits below the cache and is the responder side of the cache/memory handshake. It accepts one whole-line request at a time, models a fixed access latency, and returns read data with a one-cycle valid pulse.

---
 rtl/dmem_pkg.sv | 6 +
 rtl/line_memory_responder_if.sv | 18 +
 rtl/line_ram.sv | 22 ++
 rtl/line_memory_responder.sv | 71 +++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and sizing constants for the line memory responder.
package dmem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int CNT_W = 8;
  localparam int BYTE_BITS = 8;
endpackage

// File: rtl/line_memory_responder_if.sv
// line_memory_responder_if: whole-line request/response handshake between cache (master) and memory (slave).
interface line_memory_responder_if
  import dmem_pkg::*;
#(parameter int BLOCK_SIZE = 16);
  localparam int W = BLOCK_SIZE * BYTE_BITS;
  logic is_input_valid;
  logic [31:0] addr;
  logic mem_read;
  logic mem_write;
  logic [W-1:0] din;
  logic mem_ready;
  logic is_output_valid;
  logic [W-1:0] dout;
  modport master(output is_input_valid, addr, mem_read, mem_write, din,
                 input mem_ready, is_output_valid, dout);
  modport slave(input is_input_valid, addr, mem_read, mem_write, din,
                output mem_ready, is_output_valid, dout);
endinterface

// File: rtl/line_ram.sv
// line_ram: DEPTH x W storage, one synchronous port; reset clears only the read register.
module line_ram #(
  parameter int DEPTH = 1024,
  parameter int W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (en && !we) rdata <= mem[idx];
  end
endmodule

// File: rtl/line_memory_responder.sv
// line_memory_responder: fixed-latency line memory answering cache fills and write-backs.
// Optional DMEM_PERF_CNT_EN adds read_count/write_count completion counters.
module line_memory_responder
  import dmem_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 50
) (
  input logic clk,
  input logic reset,
  line_memory_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);
  localparam int W = BLOCK_SIZE * BYTE_BITS;
  localparam int IW = $clog2(DEPTH);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] idx;
  logic wr, valid, done, accept;
  logic [W-1:0] wdata, rdata;
  logic unused_addr_hi;
  assign accept = state == IDLE && bus.is_input_valid && (bus.mem_read || bus.mem_write);
  assign done = state == BUSY && cnt == '0;
  assign bus.mem_ready = state == IDLE;
  assign bus.is_output_valid = valid;
  assign bus.dout = rdata;
  assign unused_addr_hi = ^bus.addr[31:IW];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      valid <= 1'b0;
    end else begin
      valid <= done && !wr;
      if (accept) begin
        state <= BUSY;
        cnt <= CNT_W'(LATENCY - 1);
        idx <= bus.addr[IW-1:0];
        wr <= bus.mem_write;
        wdata <= bus.din;
      end else if (done) state <= IDLE;
      else if (state == BUSY) cnt <= cnt - 1'b1;
    end
  end
  // gating with reset keeps an aborted request from touching the array
  line_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk(clk),
    .reset(reset),
    .en(done && !reset),
    .we(wr),
    .idx(idx),
    .wdata(wdata),
    .rdata(rdata)
  );
`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count <= '0;
      write_count <= '0;
    end else if (done) begin
      read_count <= read_count + 32'(!wr);
      write_count <= write_count + 32'(wr);
    end
  end
`endif
endmodule
